// File: rtl/pattern_detect_pkg.sv
// Shared types and seven-segment codes for the serial pattern detector.
package pattern_detect_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0011000;
    localparam logic [6:0] SEG_ERR = 7'b0000111;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern.
module seg7_decode
    import pattern_detect_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/pattern_detect_counter.sv
// Mealy serial-pattern detector with runtime-loadable pattern, BCD match
// counter (wrap or saturate) and per-digit seven-segment outputs.
module pattern_detect_counter
    import pattern_detect_pkg::*;
#(
    parameter int PAT_LEN    = 4,
    parameter int NUM_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    sig_to_test,
    input  logic [PAT_LEN-1:0]      pattern,
    input  logic                    pat_load,
    input  logic                    overlap,
    input  logic                    saturate,
    output logic                    z,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic [7*NUM_DIGITS-1:0] disp
);

    localparam int                FILL_W    = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-1:0]      pat_reg;
    logic [PAT_LEN-2:0]      hist;
    logic [FILL_W-1:0]       fill;
    logic [PAT_LEN-1:0]      window;
    logic [4*NUM_DIGITS-1:0] count_inc;
    logic                    all_nines;
    logic                    carry;

    // Window holds the last PAT_LEN-1 bits plus the bit on the wire now,
    // which is what makes the detect flag zero-latency.
    assign window = {hist, sig_to_test};

    assign z = ena & ~rst & ~pat_load & (fill == FILL_FULL) & (window == pat_reg);

    always_comb begin
        count_inc = count_bcd;
        carry     = 1'b1;
        all_nines = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (count_bcd[4*k +: 4] != BCD_MAX) all_nines = 1'b0;
            if (carry) begin
                if (count_bcd[4*k +: 4] >= BCD_MAX) begin
                    count_inc[4*k +: 4] = '0;
                end else begin
                    count_inc[4*k +: 4] = count_bcd[4*k +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_reg   <= '0;
            hist      <= '0;
            fill      <= '0;
            count_bcd <= '0;
            overflow  <= 1'b0;
        end else if (ena) begin
            if (pat_load) begin
                pat_reg <= pattern;
                fill    <= '0;
            end else begin
                hist <= window[PAT_LEN-2:0];
                // Clearing fill alone is enough to retire the matched bits.
                if (z && !overlap)
                    fill <= '0;
                else if (fill != FILL_FULL)
                    fill <= fill + FILL_W'(1);
                if (z) begin
                    if (all_nines) begin
                        overflow <= 1'b1;
                        if (!saturate) count_bcd <= '0;
                    end else begin
                        count_bcd <= count_inc;
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_seg
        seg7_decode u_seg (
            .bcd (count_bcd[4*k +: 4]),
            .seg (disp[7*k +: 7])
        );
    end

endmodule

// File: tb/tb_pattern_detect_counter.sv
// Directed bench for pattern_detect_counter (PAT_LEN=4, NUM_DIGITS=2).
module tb_pattern_detect_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        sig_to_test = 1'b0;
    logic [3:0]  pattern = 4'b0000;
    logic        pat_load = 1'b0;
    logic        overlap = 1'b1;
    logic        saturate = 1'b1;
    logic        z;
    logic        overflow;
    logic [7:0]  count_bcd;
    logic [13:0] disp;

    int   n_asserts = 0;
    int   n_fail    = 0;
    int   exp_cnt   = 0;
    logic exp_ovf   = 1'b0;
    logic exp_q[$];

    pattern_detect_counter #(.PAT_LEN(4), .NUM_DIGITS(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .sig_to_test (sig_to_test),
        .pattern     (pattern),
        .pat_load    (pat_load),
        .overlap     (overlap),
        .saturate    (saturate),
        .z           (z),
        .overflow    (overflow),
        .count_bcd   (count_bcd),
        .disp        (disp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0011000;
            default: return 7'b0000111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One enabled/disabled cycle: drive at negedge, check z before the posedge.
    task automatic step(input logic s, input logic e, input logic ld,
                        input logic [3:0] pat, input logic exp_z, input string tag);
        @(negedge clk);
        sig_to_test = s;
        ena         = e;
        pat_load    = ld;
        pattern     = pat;
        exp_q.push_back(exp_z);
        #2;
        check(tag, {31'd0, z}, {31'd0, exp_q.pop_front()});
        if (exp_z && e) begin
            if (exp_cnt == 99) begin
                exp_ovf = 1'b1;
                if (!saturate) exp_cnt = 0;
            end else begin
                exp_cnt++;
            end
        end
        @(posedge clk);
        #1;
        ena      = 1'b0;
        pat_load = 1'b0;
    endtask

    task automatic check_state(input string tag);
        logic [7:0]  eb;
        logic [13:0] ed;
        eb = {4'(exp_cnt / 10), 4'(exp_cnt % 10)};
        ed = {seg_of(exp_cnt / 10), seg_of(exp_cnt % 10)};
        check({tag, ".count"}, {24'd0, count_bcd}, {24'd0, eb});
        check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
        check({tag, ".disp"}, {18'd0, disp}, {18'd0, ed});
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        ena = 1'b1;
        sig_to_test = 1'b1;
        exp_q.push_back(1'b0);
        #2;
        check({tag, ".z_in_rst"}, {31'd0, z}, {31'd0, exp_q.pop_front()});
        @(posedge clk);
        #1;
        rst = 1'b0;
        ena = 1'b0;
        exp_cnt = 0;
        exp_ovf = 1'b0;
        check_state(tag);
    endtask

    initial begin
        int i;
        do_reset("reset");

        // Overlapping matches share bits
        overlap = 1'b1;
        step(0, 1, 1, 4'b1011, 0, "t1.load");
        step(1, 1, 0, 4'b0, 0, "t1.b1");
        step(0, 1, 0, 4'b0, 0, "t1.b2");
        step(1, 1, 0, 4'b0, 0, "t1.b3");
        step(1, 1, 0, 4'b0, 1, "t1.b4");
        step(0, 1, 0, 4'b0, 0, "t1.b5");
        step(1, 1, 0, 4'b0, 0, "t1.b6");
        step(1, 1, 0, 4'b0, 1, "t1.b7");
        check_state("t1");

        do_reset("t2.rst");
        overlap = 1'b0;
        step(0, 1, 1, 4'b1011, 0, "t2.load");
        step(1, 1, 0, 4'b0, 0, "t2.b1");
        step(0, 1, 0, 4'b0, 0, "t2.b2");
        step(1, 1, 0, 4'b0, 0, "t2.b3");
        step(1, 1, 0, 4'b0, 1, "t2.b4");
        step(0, 1, 0, 4'b0, 0, "t2.b5");
        step(1, 1, 0, 4'b0, 0, "t2.b6");
        step(1, 1, 0, 4'b0, 0, "t2.b7");
        check_state("t2");

        // Fill guard
        overlap = 1'b1;
        step(1, 1, 1, 4'b0000, 0, "t3.load");
        step(0, 1, 0, 4'b0, 0, "t3.b1");
        step(0, 1, 0, 4'b0, 0, "t3.b2");
        step(0, 1, 0, 4'b0, 0, "t3.b3");
        step(0, 1, 0, 4'b0, 1, "t3.b4");
        step(0, 1, 0, 4'b0, 1, "t3.b5");
        check_state("t3");

        // Enable gap holds progress
        step(0, 1, 1, 4'b1011, 0, "t4.load");
        step(1, 1, 0, 4'b0, 0, "t4.b1");
        step(0, 1, 0, 4'b0, 0, "t4.b2");
        for (i = 0; i < 3; i++) step(1, 0, 0, 4'b0, 0, "t4.gap");
        check_state("t4.gap");
        step(1, 1, 0, 4'b0, 0, "t4.b3");
        step(1, 1, 0, 4'b0, 1, "t4.b4");
        check_state("t4");

        // Load in the would-be match cycle suppresses it; new pattern needs full fill
        step(0, 1, 1, 4'b1011, 0, "t7.load");
        step(1, 1, 0, 4'b0, 0, "t7.b1");
        step(0, 1, 0, 4'b0, 0, "t7.b2");
        step(1, 1, 0, 4'b0, 0, "t7.b3");
        step(1, 1, 1, 4'b0110, 0, "t7.load_hit");
        check_state("t7.nocount");
        step(0, 1, 0, 4'b0, 0, "t7.n1");
        step(1, 1, 0, 4'b0, 0, "t7.n2");
        step(1, 1, 0, 4'b0, 0, "t7.n3");
        step(0, 1, 0, 4'b0, 1, "t7.n4");
        // Load with ena low is ignored; overlapping 0110 still found
        step(0, 0, 1, 4'b1111, 0, "t7.load_ign");
        step(1, 1, 0, 4'b0, 0, "t7.o1");
        step(1, 1, 0, 4'b0, 0, "t7.o2");
        step(0, 1, 0, 4'b0, 1, "t7.o3");
        check_state("t7");

        // Run the counter up to 99, then saturate and wrap
        saturate = 1'b1;
        step(1, 1, 1, 4'b0000, 0, "t5.load");
        for (i = 0; i < 3; i++) step(0, 1, 0, 4'b0, 0, "t5.fill");
        while (exp_cnt < 99) step(0, 1, 0, 4'b0, 1, "t5.run");
        check_state("t5.at99");
        step(0, 1, 0, 4'b0, 1, "t5.sat");
        check_state("t5.sat");
        check("t5.sat_val", {24'd0, count_bcd}, 32'h99);
        saturate = 1'b0;
        step(0, 1, 0, 4'b0, 1, "t5.wrap");
        check_state("t5.wrap");
        check("t5.wrap_disp", {18'd0, disp}, {18'd0, 14'b1000000_1000000});

        // Reset mid-match
        step(0, 1, 1, 4'b1011, 0, "t6.load");
        step(1, 1, 0, 4'b0, 0, "t6.b1");
        step(0, 1, 0, 4'b0, 0, "t6.b2");
        step(1, 1, 0, 4'b0, 0, "t6.b3");
        do_reset("t6.rst");
        step(1, 1, 0, 4'b0, 0, "t6.b4");
        check_state("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
